// File: rtl/product_accumulator.sv
// Accumulates BEATS adder-tree sums into one ACC_WIDTH result with overflow flag.
// Define PRODUCT_ACCUMULATOR_SATURATION_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int BEATS      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_ovf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int CW = (BEATS > 1) ? $clog2(BEATS + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [1:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH:0]   sum;
  logic                 take;
  logic                 last;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

  assign take = in_valid & in_ready & ~clear;
  assign last = (cnt_q == LAST);
  assign sum  = {1'b0, acc_q} + (ACC_WIDTH + 1)'(in_data);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (take) begin
`ifdef PRODUCT_ACCUMULATOR_SATURATION_EN
            // once clamped, any further carry keeps it pinned at max
            acc_d = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
            acc_d = sum[ACC_WIDTH-1:0];
`endif
            ovf_d   = ovf_q | sum[ACC_WIDTH];
            cnt_d   = cnt_q + CW'(1);
            state_d = last ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: three instances
// (8-bit/4 beats, 5-bit/4 beats, 8-bit/1 beat) share one input stream.
module tb_product_accumulator;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;
  logic [2:0] out_ready;
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [2:0] out_ovf;
  logic [7:0] od0;
  logic [4:0] od1;
  logic [7:0] od2;

  int checks   = 0;
  int failures = 0;

  int qd[3][$];
  bit qo[3][$];
  int psum[3];
  int pcnt[3];
  int last_d[3];
  bit last_o[3];
  int nres[3];

  product_accumulator #(
    .DATA_WIDTH(4), .ACC_WIDTH(8), .BEATS(4)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_data(in_data), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(od0),
    .out_ovf(out_ovf[0])
  );

  product_accumulator #(
    .DATA_WIDTH(4), .ACC_WIDTH(5), .BEATS(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_data(in_data), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(od1),
    .out_ovf(out_ovf[1])
  );

  product_accumulator #(
    .DATA_WIDTH(4), .ACC_WIDTH(8), .BEATS(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready[2]),
    .in_data(in_data), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(od2),
    .out_ovf(out_ovf[2])
  );

  function automatic int aw(int k);
    return (k == 1) ? 5 : 8;
  endfunction

  function automatic int nb(int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic int dout(int k);
    case (k)
      0:       return int'(od0);
      1:       return int'(od1);
      default: return int'(od2);
    endcase
  endfunction

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  // Monitor + reference model, evaluated mid-cycle while inputs are stable
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        qd[k].delete();
        qo[k].delete();
        psum[k] = 0;
        pcnt[k] = 0;
        check($sformatf("rst_valid%0d", k), int'(out_valid[k]), 0);
        check($sformatf("rst_ready%0d", k), int'(in_ready[k]), 1);
      end else begin
        check($sformatf("valid%0d", k), int'(out_valid[k]),
              (qd[k].size() != 0) ? 1 : 0);
        check($sformatf("in_ready%0d", k), int'(in_ready[k]),
              (qd[k].size() == 0) ? 1 : 0);
        if (out_valid[k] && qd[k].size() != 0) begin
          check($sformatf("data%0d", k), dout(k), qd[k][0]);
          check($sformatf("ovf%0d", k), int'(out_ovf[k]),
                int'(qo[k][0]));
          if (out_ready[k] && !clear) begin
            last_d[k] = qd[k].pop_front();
            last_o[k] = qo[k].pop_front();
            nres[k]++;
          end
        end
        if (clear) begin
          qd[k].delete();
          qo[k].delete();
          psum[k] = 0;
          pcnt[k] = 0;
        end else if (in_valid && in_ready[k]) begin
          psum[k] += int'(in_data);
          pcnt[k]++;
          if (pcnt[k] == nb(k)) begin
            int mx;
            mx = (1 << aw(k)) - 1;
`ifdef PRODUCT_ACCUMULATOR_SATURATION_EN
            qd[k].push_back((psum[k] > mx) ? mx : psum[k]);
`else
            qd[k].push_back(psum[k] % (mx + 1));
`endif
            qo[k].push_back(psum[k] > mx);
            psum[k] = 0;
            pcnt[k] = 0;
          end
        end
      end
    end
  end

  task automatic beat(input logic v, input int d,
                      input logic c);
    in_valid = v;
    in_data  = 4'(d);
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) beat(1'b0, 0, 1'b0);
  endtask

  initial begin
    int base;
    int n;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", int'(in_ready), 7);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_data0", int'(od0), 0);
    check("reset_data1", int'(od1), 0);
    check("reset_ovf", int'(out_ovf), 0);
    rst_n = 1'b1;
    idle(2);

    // back-to-back 3,5,7,9
    beat(1'b1, 3, 1'b0);
    beat(1'b1, 5, 1'b0);
    beat(1'b1, 7, 1'b0);
    beat(1'b1, 9, 1'b0);
    check("seqA_valid", int'(out_valid[0]), 1);
    check("seqA_data", int'(od0), 24);
    check("seqA_ovf", int'(out_ovf[0]), 0);
    idle(1);
    check("seqA_idle", int'(out_valid[0]), 0);
    check("seqA_ready", int'(in_ready[0]), 1);
    idle(2);

    // held result under backpressure
    out_ready = 3'b100;
    beat(1'b1, 1, 1'b0);
    beat(1'b1, 2, 1'b0);
    beat(1'b1, 3, 1'b0);
    beat(1'b1, 4, 1'b0);
    repeat (5) begin
      beat(1'b1, 15, 1'b0);
      check("seqB_valid", int'(out_valid[0]), 1);
      check("seqB_data", int'(od0), 10);
      check("seqB_ready", int'(in_ready[0]), 0);
    end
    out_ready = 3'b111;
    idle(1);
    check("seqB_release", int'(out_valid[0]), 0);
    check("seqB_last", last_d[0], 10);
    idle(2);

    // overflow on the 5-bit instance
    repeat (4) beat(1'b1, 15, 1'b0);
`ifdef PRODUCT_ACCUMULATOR_SATURATION_EN
    check("seqC_data1", int'(od1), 31);
`else
    check("seqC_data1", int'(od1), 28);
`endif
    check("seqC_ovf1", int'(out_ovf[1]), 1);
    check("seqC_data0", int'(od0), 60);
    check("seqC_ovf0", int'(out_ovf[0]), 0);
    idle(3);

    // clear discards partial sum and the coincident beat
    beat(1'b1, 6, 1'b0);
    beat(1'b1, 6, 1'b0);
    beat(1'b1, 6, 1'b1);
    repeat (4) beat(1'b1, 1, 1'b0);
    check("seqD_valid", int'(out_valid[0]), 1);
    check("seqD_data", int'(od0), 4);
    idle(3);

    // reset mid-accumulation
    base = nres[0];
    beat(1'b1, 1, 1'b0);
    beat(1'b1, 2, 1'b0);
    beat(1'b1, 3, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) beat(1'b1, 2, 1'b0);
    idle(3);
    check("seqE_count", nres[0] - base, 1);
    check("seqE_data", last_d[0], 8);

    // single-beat instance with in_valid held
    beat(1'b1, 7, 1'b0);
    check("seqF_v1", int'(out_valid[2]), 1);
    check("seqF_d1", int'(od2), 7);
    check("seqF_hold_rdy", int'(in_ready[2]), 0);
    beat(1'b1, 9, 1'b0);
    check("seqF_gap", int'(out_valid[2]), 0);
    beat(1'b1, 9, 1'b0);
    check("seqF_v2", int'(out_valid[2]), 1);
    check("seqF_d2", int'(od2), 9);
    idle(3);
    check("seqF_last", last_d[2], 9);

    // randomized traffic
    repeat (600) begin
      out_ready = 3'($urandom);
      beat($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 15)),
           $urandom_range(0, 49) == 0);
    end

    out_ready = 3'b111;
    n = 0;
    while (n < 20 && (qd[0].size() + qd[1].size()
                      + qd[2].size()) != 0) begin
      idle(1);
      n++;
    end
    check("drain", qd[0].size() + qd[1].size()
          + qd[2].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the width of each adder-tree sum word consumed.
REQ-002 Parameter ACC_WIDTH, default 8, SHALL set the accumulator/result width, legal only when ACC_WIDTH >= DATA_WIDTH.
REQ-003 Parameter BEATS, default 4, SHALL set the number of sum words per result, legal only when BEATS >= 1.
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 Port clear  input  1  SHALL be a synchronous abort of the current accumulation.
REQ-007 Port in_valid  input  1  SHALL flag in_data valid.
REQ-008 Port in_ready  output  1  SHALL flag that the block accepts a word this cycle.
REQ-009 Port in_data  input  DATA_WIDTH  SHALL carry the unsigned sum from the upstream adder tree.
REQ-010 Port out_valid  output  1  SHALL flag that out_data holds a finished result.
REQ-011 Port out_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-012 Port out_data  output  ACC_WIDTH  SHALL carry the accumulated result.
REQ-013 Port out_ovf  output  1  SHALL flag that the result exceeded 2**ACC_WIDTH-1 at some beat.

Function
REQ-014 The FSM SHALL have states IDLE (no beat taken), ACCUM (1..BEATS-1 beats taken) and HOLD (result presented).
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD; a beat is accepted when in_valid && in_ready && !clear.
REQ-016 Each accepted in_data SHALL be zero-extended to ACC_WIDTH and added to the accumulator; the beat counter SHALL increment.
REQ-017 IDLE -> ACCUM on an accepted beat when BEATS > 1; ACCUM stays in ACCUM until the BEATS-th accepted beat.
REQ-018 On the BEATS-th accepted beat the FSM SHALL enter HOLD, with out_data = final sum and out_valid = 1 in the next cycle (latency 1 cycle after last beat).
REQ-019 With BEATS = 1, every accepted beat SHALL go directly IDLE -> HOLD.
REQ-020 In HOLD, out_data and out_ovf SHALL remain stable while out_valid && !out_ready.
REQ-021 HOLD -> IDLE on out_valid && out_ready; accumulator, counter and out_ovf SHALL clear that edge; out_valid SHALL be 0 the next cycle.
REQ-022 No beat SHALL be accepted in the handshake-completion cycle (in_ready is 0 in HOLD); first new beat accepted at the earliest in the next cycle.
REQ-023 in_valid idle cycles in ACCUM SHALL leave accumulator and counter unchanged.
REQ-024 clear SHALL have priority over all other events: next state IDLE, accumulator, counter, out_valid, out_ovf, out_data all 0; a beat presented with clear is discarded.
REQ-025 out_ovf SHALL be set when any addition carries out of ACC_WIDTH bits, and remain set until the result is consumed, clear, or reset.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, accumulator 0, counter 0, out_valid 0, out_data 0, out_ovf 0, in_ready 1 (after reset).
REQ-027 Reset asserted mid-accumulation or in HOLD SHALL discard all partial or pending results; no out_valid pulse SHALL follow deassertion.

Configuration
REQ-028 Macro PRODUCT_ACCUMULATOR_SATURATION_EN defined: on carry-out the accumulator SHALL clamp to 2**ACC_WIDTH-1 and stay there for the remaining beats; out_ovf set.
REQ-029 Macro PRODUCT_ACCUMULATOR_SATURATION_EN undefined: addition SHALL wrap modulo 2**ACC_WIDTH; out_ovf set on any carry-out.

Verification (DATA_WIDTH=4, ACC_WIDTH=8, BEATS=4 unless stated)
REQ-030 Beats 3,5,7,9 back-to-back, out_ready=1 -> out_valid one cycle after 4th beat, out_data=24, out_ovf=0, back to IDLE.
REQ-031 Beats 1,2,3,4 with out_ready=0 for 5 cycles -> out_valid held, out_data=10 stable, in_ready=0 throughout HOLD; released on out_ready=1.
REQ-032 ACC_WIDTH=5, beats 15,15,15,15 -> wrap build: out_data=28, out_ovf=1; saturation build: out_data=31, out_ovf=1.
REQ-033 Beats 6,6, then clear with in_valid=1 and in_data=6, then beats 1,1,1,1 -> out_data=4 (cleared and discarded beats excluded).
REQ-034 rst_n pulsed low after 3 beats, then beats 2,2,2,2 -> exactly one out_valid with out_data=8.
REQ-035 BEATS=1, beats 7 and 9 with out_ready=1 and in_valid held -> results 7 then 9, each one cycle after acceptance, no beat accepted during HOLD.
